// File: rtl/ifu_issue_ctl.sv
// Integer functional unit issue controller: decodes one RV32IM R-type/OP-IMM op,
// drives registered ALU/MUL/DIV controls and holds the result select for the unit latency.
//   state | meaning
//   IDLE  | ready to accept an instruction
//   WAIT  | MUL/DIV started, counting down the fixed unit latency
//   DONE  | result valid at ifuresmux, waiting for out_ready
module ifu_issue_ctl #(
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 34,
  parameter int IFURES_N = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [6:0]                  opcode,
  input  logic [2:0]                  func3,
  input  logic [1:0]                  func7b50,
  output logic [3:0]                  aluctl,
  output logic [1:0]                  mulctl,
  output logic [1:0]                  divctl,
  output logic [$clog2(IFURES_N)-1:0] ifuresctl,
  output logic                        unit_start,
  output logic                        busy,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        illegal
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam int IW      = $clog2(IFURES_N);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {K_ALU = 2'd0, K_MUL = 2'd1, K_DIV = 2'd2} kind_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      aluctl_q, aluctl_d;
  logic [1:0]      mulctl_q, mulctl_d;
  logic [1:0]      divctl_q, divctl_d;
  logic [IW-1:0]   ifuresctl_q, ifuresctl_d;
  logic            unit_start_q, unit_start_d;
  logic            illegal_q, illegal_d;

  logic            dec_legal;
  logic            dec_eff;
  kind_t           dec_kind;
  logic            accept;

  always_comb begin
    dec_legal = 1'b0;
    dec_eff   = 1'b0;
    dec_kind  = K_ALU;
    case (opcode)
      7'b0110011: begin
        case (func7b50)
          2'b01: begin
            dec_legal = 1'b1;
            dec_kind  = func3[2] ? K_DIV : K_MUL;
          end
          2'b00: dec_legal = 1'b1;
          2'b10: begin
            dec_legal = (func3 == 3'b000) || (func3 == 3'b101);
            dec_eff   = 1'b1;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        if (func3 == 3'b001) begin
          dec_legal = (func7b50 == 2'b00);
        end else if (func3 == 3'b101) begin
          dec_legal = !func7b50[0];
          dec_eff   = func7b50[1];
        end else begin
          dec_legal = 1'b1;
        end
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign in_ready = (state_q == IDLE) && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    aluctl_d     = aluctl_q;
    mulctl_d     = mulctl_q;
    divctl_d     = divctl_q;
    ifuresctl_d  = ifuresctl_q;
    illegal_d    = illegal_q;
    unit_start_d = 1'b0;
    if (flush) begin
      state_d   = IDLE;
      cnt_d     = '0;
      illegal_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            // only the field of the selected unit is loaded; others read 0
            aluctl_d    = '0;
            mulctl_d    = '0;
            divctl_d    = '0;
            ifuresctl_d = '0;
            illegal_d   = !dec_legal;
            state_d     = DONE;
            if (dec_legal) begin
              case (dec_kind)
                K_MUL: begin
                  mulctl_d     = func3[1:0];
                  ifuresctl_d  = IW'(1);
                  cnt_d        = CW'(MUL_LAT);
                  unit_start_d = 1'b1;
                  state_d      = WAIT;
                end
                K_DIV: begin
                  divctl_d     = func3[1:0];
                  ifuresctl_d  = IW'(2);
                  cnt_d        = CW'(DIV_LAT);
                  unit_start_d = 1'b1;
                  state_d      = WAIT;
                end
                default: aluctl_d = {dec_eff, func3};
              endcase
            end
          end
        end
        WAIT: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_d   = IDLE;
            illegal_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      aluctl_q     <= '0;
      mulctl_q     <= '0;
      divctl_q     <= '0;
      ifuresctl_q  <= '0;
      unit_start_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      aluctl_q     <= aluctl_d;
      mulctl_q     <= mulctl_d;
      divctl_q     <= divctl_d;
      ifuresctl_q  <= ifuresctl_d;
      unit_start_q <= unit_start_d;
      illegal_q    <= illegal_d;
    end
  end

  assign aluctl     = aluctl_q;
  assign mulctl     = mulctl_q;
  assign divctl     = divctl_q;
  assign ifuresctl  = ifuresctl_q;
  assign unit_start = unit_start_q;
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_ifu_issue_ctl.sv
// Bench for ifu_issue_ctl: directed literal checks then random traffic against
// a cycle-count model of when each op's result becomes valid.
module tb_ifu_issue_ctl;
  localparam int MUL_LAT  = 3;
  localparam int DIV_LAT  = 34;
  localparam int IFURES_N = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] opcode = '0;
  logic [2:0] func3 = '0;
  logic [1:0] func7b50 = '0;
  logic [3:0] aluctl;
  logic [1:0] mulctl;
  logic [1:0] divctl;
  logic [1:0] ifuresctl;
  logic       unit_start;
  logic       busy;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       illegal;

  ifu_issue_ctl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .IFURES_N(IFURES_N)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func3(func3), .func7b50(func7b50), .aluctl(aluctl),
    .mulctl(mulctl), .divctl(divctl), .ifuresctl(ifuresctl), .unit_start(unit_start),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model: one op in flight, identified by the cycle its result turns valid
  int  cyc = 0;
  bit  m_pend = 0;
  int  m_ready_at = 0;
  int  m_start_at = -1;
  int  m_kind = 0;      // 0 ALU, 1 MUL, 2 DIV, 3 illegal
  bit  m_eff = 0;
  logic [2:0] m_f3 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void decode(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [1:0] f7, output int kind, output bit eff);
    kind = 3;
    eff  = 0;
    if (op == 7'b0110011) begin
      if (f7 == 2'b01) kind = (f3 >= 3'd4) ? 2 : 1;
      else if (f7 == 2'b00) kind = 0;
      else if (f7 == 2'b10 && (f3 == 3'd0 || f3 == 3'd5)) begin kind = 0; eff = 1; end
    end else if (op == 7'b0010011) begin
      if (f3 == 3'd1) kind = (f7 == 2'b00) ? 0 : 3;
      else if (f3 == 3'd5) begin
        if (f7 == 2'b00 || f7 == 2'b10) begin kind = 0; eff = (f7 == 2'b10); end
      end else kind = 0;
    end
  endfunction

  // compare DUT against model for the current cycle, then advance one clock
  task automatic cycle();
    bit exp_ov;
    int kind;
    bit eff;
    #1;
    exp_ov = m_pend && (cyc >= m_ready_at);
    chk("out_valid", out_valid, exp_ov);
    chk("busy", busy, m_pend);
    chk("unit_start", unit_start, (cyc == m_start_at));
    chk("in_ready", in_ready, !m_pend && !flush);
    chk("illegal", illegal, exp_ov && (m_kind == 3));
    if (m_pend) begin
      chk("ifuresctl", ifuresctl, (m_kind == 3) ? 0 : m_kind);
      if (m_kind == 0) chk("aluctl", aluctl, {m_eff, m_f3});
      if (m_kind == 1) chk("mulctl", mulctl, m_f3[1:0]);
      if (m_kind == 2) chk("divctl", divctl, m_f3[1:0]);
      if (m_kind == 3) chk("illegal_fields_zero", {aluctl, mulctl, divctl}, 0);
    end
    if (rst || flush) m_pend = 0;
    else if (exp_ov && out_ready) m_pend = 0;
    else if (in_valid && !m_pend) begin
      decode(opcode, func3, func7b50, kind, eff);
      m_pend = 1;
      m_kind = kind;
      m_eff  = eff;
      m_f3   = func3;
      m_ready_at = cyc + 1 + ((kind == 1) ? MUL_LAT : (kind == 2) ? DIV_LAT : 0);
      m_start_at = (kind == 1 || kind == 2) ? cyc + 1 : -1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input bit v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [1:0] f7);
    in_valid = v;
    opcode   = op;
    func3    = f3;
    func7b50 = f7;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_unit_start", unit_start, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_fields", {aluctl, mulctl, divctl, ifuresctl}, 0);
    rst = 0;
    cyc = 0;
    m_pend = 0;

    // add, ALU path
    out_ready = 1;
    drive(1, 7'b0110011, 3'b000, 2'b00);
    cycle();
    drive(0, 0, 0, 0);
    #1;
    chk("add_out_valid_T1", out_valid, 1);
    chk("add_aluctl", aluctl, 4'b0000);
    chk("add_ifuresctl", ifuresctl, 0);
    chk("add_in_ready_T1", in_ready, 0);
    cycle();
    #1;
    chk("add_in_ready_T2", in_ready, 1);

    // srai
    drive(1, 7'b0010011, 3'b101, 2'b10);
    cycle();
    drive(0, 0, 0, 0);
    #1;
    chk("srai_aluctl", aluctl, 4'b1101);
    chk("srai_illegal", illegal, 0);
    cycle();

    // slli with funct7[0] set is not a valid shift
    drive(1, 7'b0010011, 3'b001, 2'b01);
    cycle();
    drive(0, 0, 0, 0);
    #1;
    chk("slli_bad_illegal", illegal, 1);
    chk("slli_bad_out_valid", out_valid, 1);
    cycle();

    // mulhsu
    drive(1, 7'b0110011, 3'b010, 2'b01);
    cycle();
    drive(0, 0, 0, 0);
    #1;
    chk("mul_start_T1", unit_start, 1);
    cycle();
    #1;
    chk("mul_start_T2", unit_start, 0);
    chk("mul_out_valid_T2", out_valid, 0);
    cycle();
    #1;
    chk("mul_out_valid_T3", out_valid, 0);
    cycle();
    #1;
    chk("mul_out_valid_T4", out_valid, 1);
    chk("mulhsu_mulctl", mulctl, 2'b10);
    chk("mul_ifuresctl", ifuresctl, 1);
    cycle();

    // remu with backpressure
    out_ready = 0;
    drive(1, 7'b0110011, 3'b111, 2'b01);
    cycle();
    drive(0, 0, 0, 0);
    repeat (33) cycle();
    #1;
    chk("div_out_valid_T34", out_valid, 0);
    cycle();
    #1;
    chk("div_out_valid_T35", out_valid, 1);
    chk("remu_divctl", divctl, 2'b11);
    chk("div_ifuresctl", ifuresctl, 2);
    repeat (5) begin
      #1;
      chk("div_hold_in_ready", in_ready, 0);
      chk("div_hold_divctl", divctl, 2'b11);
      cycle();
    end
    out_ready = 1;
    cycle();
    #1;
    chk("div_after_hs_in_ready", in_ready, 1);
    chk("div_after_hs_out_valid", out_valid, 0);

    // xor with funct7[5] set is illegal
    drive(1, 7'b0110011, 3'b100, 2'b10);
    cycle();
    drive(0, 0, 0, 0);
    #1;
    chk("xor_bad_out_valid", out_valid, 1);
    chk("xor_bad_illegal", illegal, 1);
    chk("xor_bad_fields", {aluctl, mulctl, divctl, ifuresctl}, 0);
    cycle();

    // flush during a divide, then a fresh add
    drive(1, 7'b0110011, 3'b100, 2'b01);
    cycle();
    drive(0, 0, 0, 0);
    repeat (9) cycle();
    flush = 1;
    cycle();
    flush = 0;
    #1;
    chk("flush_busy", busy, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    drive(1, 7'b0110011, 3'b000, 2'b00);
    cycle();
    drive(0, 0, 0, 0);
    #1;
    chk("post_flush_add_valid", out_valid, 1);
    cycle();

    // flush blocks a simultaneous accept
    flush = 1;
    drive(1, 7'b0110011, 3'b000, 2'b00);
    #1;
    chk("flush_accept_in_ready", in_ready, 0);
    cycle();
    flush = 0;
    drive(0, 0, 0, 0);
    #1;
    chk("flush_accept_busy", busy, 0);
    chk("flush_accept_out_valid", out_valid, 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      int sel;
      sel = $urandom_range(0, 99);
      opcode   = (sel < 45) ? 7'b0110011 : (sel < 90) ? 7'b0010011 : 7'($urandom);
      func3    = 3'($urandom);
      func7b50 = 2'($urandom);
      in_valid = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 70);
      flush    = ($urandom_range(0, 99) < 3);
      rst      = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 0;
    flush = 0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
